// File: rtl/aes_state_transpose_stream.sv
`default_nettype none
// ============================================================================
// Module   : aes_state_transpose_stream
// Purpose  : Streaming Rijndael state transposer. Collects a 4 x NB byte state
//            from BEAT_W-bit beats into a ping-pong pair of banks and presents
//            the whole state row-major->column-major (R2C), column-major->
//            row-major (C2R) or unchanged (bypass), chosen per block.
// Ports    : clk, rst (async, active high)
//            flush                 - drop the partially filled bank
//            mode[1:0]             - 0 R2C, 1 C2R, 2/3 bypass (first beat only)
//            in_valid/in_ready/in  - input beat stream, big-endian bit order
//            out_valid/out_ready   - full-state handshake
//            out/out_mode          - transformed state and its mode, zero
//                                    while out_valid is low
// Revision : 1.0 - initial release
// ============================================================================
module aes_state_transpose_stream #(
  parameter int NB     = 4,
  parameter int BEAT_W = 32,
  localparam int c_SW    = 32 * NB,
  localparam int c_BEATS = c_SW / BEAT_W,
  localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:BEAT_W-1] in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:c_SW-1]   out,
  output logic [1:0]        out_mode
);

  localparam logic [1:0] c_MODE_R2C = 2'd0;
  localparam logic [1:0] c_MODE_C2R = 2'd1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);

  logic [0:c_SW-1]    r_bank [2];
  logic [1:0]         r_mode [2];
  logic [1:0]         r_full;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [c_CNT_W-1:0] r_beat_cnt;

  logic               w_accept;
  logic               w_last;
  logic               w_pop;
  logic [0:c_SW-1]    w_rd_bank;
  logic [0:c_SW-1]    w_r2c;
  logic [0:c_SW-1]    w_c2r;

  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = ~r_full[r_wr_ptr];
  assign out_valid = r_full[r_rd_ptr];

  // A flushed cycle drops any beat presented alongside it.
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_last    = (r_beat_cnt == c_LAST);
  assign w_pop     = out_valid & out_ready;

  assign w_rd_bank = r_bank[r_rd_ptr];

  // Byte permutations: (r,c) lives at NB*r+c row-major, 4c+r column-major.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      assign w_r2c[8*(4*c+r) +: 8]  = w_rd_bank[8*(NB*r+c) +: 8];
      assign w_c2r[8*(NB*r+c) +: 8] = w_rd_bank[8*(4*c+r) +: 8];
    end
  end

  always_comb begin
    out      = '0;
    out_mode = 2'd0;
    if (out_valid) begin
      out_mode = r_mode[r_rd_ptr];
      case (r_mode[r_rd_ptr])
        c_MODE_R2C: out = w_r2c;
        c_MODE_C2R: out = w_c2r;
        default:    out = w_rd_bank;
      endcase
    end
  end

  // Bank data carries no reset; it is only visible through the gated mux.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bank[r_wr_ptr][int'(r_beat_cnt)*BEAT_W +: BEAT_W] <= in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full     <= 2'b00;
      r_mode[0]  <= 2'd0;
      r_mode[1]  <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      if (flush) begin
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        if (r_beat_cnt == '0) begin
          r_mode[r_wr_ptr] <= mode;
        end
        if (w_last) begin
          r_full[r_wr_ptr] <= 1'b1;
          r_wr_ptr         <= ~r_wr_ptr;
          r_beat_cnt       <= '0;
        end else begin
          r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
        end
      end
      // A fill only targets an empty bank and a pop only a full one, so the
      // two updates never touch the same flag.
      if (w_pop) begin
        r_full[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= ~r_rd_ptr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_state_transpose_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_state_transpose_stream
// Purpose  : Directed bench for aes_state_transpose_stream. One instance with
//            NB=4/BEAT_W=32 and one with NB=6/BEAT_W=64 share clk and rst.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_state_transpose_stream;

  localparam logic [127:0] c_A  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] c_TA = 128'h0004080C0105090D02060A0E03070B0F;
  localparam logic [127:0] c_B  = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] c_C  = 128'h202122232425262728292A2B2C2D2E2F;
  localparam logic [191:0] c_D6 = 192'h000102030405060708090A0B0C0D0E0F1011121314151617;
  localparam logic [191:0] c_T6 = 192'h0004080C1014_0105090D1115_02060A0E1216_03070B0F1317;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush4 = 1'b0, in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [1:0]    mode4 = 2'd0;
  logic [0:31]   in4 = '0;
  logic          in_ready4, out_valid4;
  logic [0:127]  out4;
  logic [1:0]    out_mode4;

  logic          flush6 = 1'b0, in_valid6 = 1'b0, out_ready6 = 1'b0;
  logic [1:0]    mode6 = 2'd0;
  logic [0:63]   in6 = '0;
  logic          in_ready6, out_valid6;
  logic [0:191]  out6;
  logic [1:0]    out_mode6;

  aes_state_transpose_stream #(.NB(4), .BEAT_W(32)) dut4 (
    .clk(clk), .rst(rst), .flush(flush4), .mode(mode4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in(in4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out(out4),
    .out_mode(out_mode4)
  );

  aes_state_transpose_stream #(.NB(6), .BEAT_W(64)) dut6 (
    .clk(clk), .rst(rst), .flush(flush6), .mode(mode6),
    .in_valid(in_valid6), .in_ready(in_ready6), .in(in6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out(out6),
    .out_mode(out_mode6)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic push4(input logic [31:0] d, input logic [1:0] m, output int waited);
    waited    = 0;
    in_valid4 = 1'b1;
    in4       = d;
    mode4     = m;
    while (!in_ready4 && waited < 20) begin
      @(posedge clk); @(negedge clk);
      waited++;
    end
    if (in_ready4) begin
      @(posedge clk); @(negedge clk);
    end else begin
      check("push4_timeout", 1'b0, 1'b1);
    end
    in_valid4 = 1'b0;
  endtask

  // Non-first beats carry a different mode, which must be ignored.
  task automatic push_block4(input logic [127:0] blk, input logic [1:0] m, input bit chk_ready);
    int w;
    for (int i = 0; i < 4; i++) begin
      push4(blk[127-32*i -: 32], (i == 0) ? m : ~m, w);
      if (chk_ready) check("b2b_no_stall", 32'(w), 32'd0);
    end
  endtask

  task automatic push6(input logic [63:0] d, input logic [1:0] m);
    int waited = 0;
    in_valid6 = 1'b1;
    in6       = d;
    mode6     = m;
    while (!in_ready6 && waited < 20) begin
      @(posedge clk); @(negedge clk);
      waited++;
    end
    if (in_ready6) begin
      @(posedge clk); @(negedge clk);
    end else begin
      check("push6_timeout", 1'b0, 1'b1);
    end
    in_valid6 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid4, 1'b0);
    check("rst_in_ready",  in_ready4,  1'b1);
    check("rst_out",       out4,       128'h0);
    check("rst_out_mode",  out_mode4,  2'd0);
    check("rst6_in_ready", in_ready6,  1'b1);

    // Test 1: NB=4 R2C, latency 1 after last beat
    out_ready4 = 1'b1;
    push4(32'h00010203, 2'd0, w);
    push4(32'h04050607, 2'd1, w);
    push4(32'h08090A0B, 2'd2, w);
    check("t1_valid_before_last", out_valid4, 1'b0);
    check("t1_out_gated",         out4,       128'h0);
    push4(32'h0C0D0E0F, 2'd3, w);
    check("t1_valid",    out_valid4, 1'b1);
    check("t1_out",      out4,       c_TA);
    check("t1_out_mode", out_mode4,  2'd0);
    @(posedge clk); @(negedge clk);
    check("t1_popped", out_valid4, 1'b0);

    // Test 3: backpressure, both banks full
    out_ready4 = 1'b0;
    push_block4(c_A, 2'd0, 1'b0);
    push_block4(c_B, 2'd2, 1'b0);
    check("t3_in_ready_full", in_ready4,  1'b0);
    check("t3_valid",         out_valid4, 1'b1);
    check("t3_out_blk1",      out4,       c_TA);
    check("t3_mode_blk1",     out_mode4,  2'd0);
    in_valid4 = 1'b1; in4 = 32'h30313233; mode4 = 2'd0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("t3_third_stalled", in_ready4, 1'b0);
    check("t3_out_stable",    out4,      c_TA);
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready4 = 1'b0;
    check("t3_valid_blk2",   out_valid4, 1'b1);
    check("t3_out_blk2",     out4,       c_B);
    check("t3_mode_blk2",    out_mode4,  2'd2);
    check("t3_in_ready_pop", in_ready4,  1'b1);
    out_ready4 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("t3_drained", out_valid4, 1'b0);

    // Test 4: back-to-back blocks alternating R2C / bypass
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) begin
        push_block4(c_A, 2'd0, 1'b1);
        check("t4_valid", out_valid4, 1'b1);
        check("t4_out_r2c", out4, c_TA);
        check("t4_mode", out_mode4, 2'd0);
      end else begin
        push_block4(c_C, 2'd2, 1'b1);
        check("t4_valid", out_valid4, 1'b1);
        check("t4_out_byp", out4, c_C);
        check("t4_mode", out_mode4, 2'd2);
      end
    end
    @(posedge clk); @(negedge clk);
    check("t4_drained", out_valid4, 1'b0);

    // Test 5: flush with a concurrent beat
    push4(32'hAAAAAAAA, 2'd2, w);
    push4(32'h55555555, 2'd2, w);
    flush4 = 1'b1; in_valid4 = 1'b1; in4 = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    flush4 = 1'b0; in_valid4 = 1'b0;
    check("t5_valid_after_flush", out_valid4, 1'b0);
    push_block4(c_A, 2'd0, 1'b0);
    check("t5_valid", out_valid4, 1'b1);
    check("t5_out",   out4,       c_TA);
    check("t5_mode",  out_mode4,  2'd0);
    @(posedge clk); @(negedge clk);

    // Test 6: async reset with one bank full and one partial
    out_ready4 = 1'b0;
    push_block4(c_C, 2'd2, 1'b0);
    push4(32'h11111111, 2'd1, w);
    push4(32'h22222222, 2'd1, w);
    check("t6_valid_pre_rst", out_valid4, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid4, 1'b0);
    check("t6_rst_out",   out4,       128'h0);
    check("t6_rst_mode",  out_mode4,  2'd0);
    @(negedge clk);
    rst = 1'b0;
    check("t6_in_ready", in_ready4,  1'b1);
    check("t6_valid",    out_valid4, 1'b0);
    out_ready4 = 1'b1;
    push_block4(c_A, 2'd0, 1'b0);
    check("t6_post_valid", out_valid4, 1'b1);
    check("t6_post_out",   out4,       c_TA);
    check("t6_post_mode",  out_mode4,  2'd0);
    @(posedge clk); @(negedge clk);

    // Test 2: NB=6, BEAT_W=64, C2R
    out_ready6 = 1'b1;
    push6(c_D6[191:128], 2'd1);
    push6(c_D6[127:64],  2'd0);
    check("t2_valid_before_last", out_valid6, 1'b0);
    push6(c_D6[63:0],    2'd2);
    check("t2_valid", out_valid6, 1'b1);
    check("t2_out",   out6,       c_T6);
    check("t2_mode",  out_mode6,  2'd1);
    @(posedge clk); @(negedge clk);
    check("t2_popped", out_valid6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
